inst_fetch: RTL and testbench



---
 rtl/inst_fetch.sv | 107 ++++++++++
 tb/tb_inst_fetch.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch: drives the combinational ROM at the PC and buffers {pc, inst} pairs
// for decode. One-cycle fetch-to-head latency; a full FIFO without a pop holds the PC.
module inst_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  input  logic              id_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              rom_ce_q, rom_ce_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic pop, push, full, redirect;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign redirect = flush || branch_flag;
  assign pop      = if_valid && id_ready;
  assign push     = rom_ce_q && !stall && !redirect && (!full || pop);

  always_comb begin
    pc_d     = pc_q;
    rom_ce_d = 1'b1;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      pc_d     = new_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else if (branch_flag) begin
      pc_d     = branch_target;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) begin
        pc_d     = pc_q + ADDR_W'(4);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rom_ce_q <= 1'b0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      rom_ce_q <= rom_ce_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= rom_inst;
    end
  end

  assign rom_ce   = rom_ce_q;
  assign rom_addr = pc_q;
  assign if_valid = (count_q != '0);
  assign if_pc    = if_valid ? pc_mem[rd_ptr_q]   : '0;
  assign if_inst  = if_valid ? inst_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: behavioural ROM, reference PC/FIFO model and a scoreboard of fetched pairs.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready = 1'b0;

  inst_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
    .branch_target(branch_target), .flush(flush), .new_pc(new_pc),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      default: return a ^ 32'hDEAD_0000;
    endcase
  endfunction

  assign rom_inst = rom_ce ? rom_word(rom_addr) : 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      sb_q[$];
  logic [31:0] m_pc;
  logic        m_ce;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("rom_ce", {31'b0, rom_ce}, {31'b0, m_ce});
    check_eq("rom_addr", rom_addr, m_pc);
    check_eq("if_valid", {31'b0, if_valid}, {31'b0, sb_q.size() != 0});
    if (sb_q.size() != 0) begin
      check_eq("if_pc", if_pc, sb_q[0].pc);
      check_eq("if_inst", if_inst, sb_q[0].inst);
    end else begin
      check_eq("if_pc_idle", if_pc, 32'h0);
      check_eq("if_inst_idle", if_inst, 32'h0);
    end
  endtask

  // One clock: drive inputs just after the falling edge, update the model on the rising
  // edge, then compare on the next falling edge.
  task automatic cycle(input logic st, input logic br, input logic [31:0] bt,
                       input logic fl, input logic [31:0] np, input logic rdy);
    logic   do_pop, do_push;
    entry_t e;
    stall = st; branch_flag = br; branch_target = bt;
    flush = fl; new_pc = np; id_ready = rdy;
    #1;
    do_pop  = (sb_q.size() != 0) && rdy;
    do_push = m_ce && !st && !fl && !br && ((sb_q.size() < 2) || do_pop);
    e.pc    = m_pc;
    e.inst  = rom_word(m_pc);
    @(posedge clk);
    if (fl) begin
      sb_q.delete();
      m_pc = np;
    end else if (br) begin
      sb_q.delete();
      m_pc = bt;
    end else begin
      if (do_pop) void'(sb_q.pop_front());
      if (do_push) begin
        sb_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    m_ce = 1'b1;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_rom_ce", {31'b0, rom_ce}, 32'h0);
    check_eq("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check_eq("rst_if_pc", if_pc, 32'h0);
    check_eq("rst_if_inst", if_inst, 32'h0);
    check_eq("rst_rom_addr", rom_addr, 32'h0);
    sb_q.delete();
    m_pc = 32'h0;
    m_ce = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    m_pc = 32'h0;
    m_ce = 1'b0;
    #3;
    check_eq("por_rom_ce", {31'b0, rom_ce}, 32'h0);
    check_eq("por_if_valid", {31'b0, if_valid}, 32'h0);
    check_eq("por_rom_addr", rom_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming after reset: 0x0/0x11, 0x4/0x22, 0x8/0x33 back to back.
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_eq("ce_after_edge", {31'b0, rom_ce}, 32'h1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_eq("first_pc", if_pc, 32'h0);
    check_eq("first_inst", if_inst, 32'h11);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_eq("second_inst", if_inst, 32'h22);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_eq("third_inst", if_inst, 32'h33);
    run(3, 1'b1);

    // Mid-stream reset, then back-pressure until the FIFO fills.
    reset_pulse();
    run(5, 1'b0);
    check_eq("full_hold_addr", rom_addr, 32'h8);
    check_eq("full_head", if_pc, 32'h0);
    run(6, 1'b1);

    // Branch while two entries are buffered.
    run(3, 1'b0);
    cycle(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    check_eq("br_valid", {31'b0, if_valid}, 32'h0);
    check_eq("br_addr", rom_addr, 32'h100);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_eq("br_head", if_pc, 32'h100);
    run(2, 1'b1);

    // Flush beats branch and stall in the same cycle.
    cycle(1'b1, 1'b1, 32'h100, 1'b1, 32'h180, 1'b1);
    check_eq("fl_addr", rom_addr, 32'h180);
    check_eq("fl_valid", {31'b0, if_valid}, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_eq("fl_head", if_pc, 32'h180);

    // Stall lets decode drain while the PC holds.
    run(2, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    run(2, 1'b1);

    // PC wrap at the top of the address space.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_eq("wrap_addr", rom_addr, 32'h0);
    check_eq("wrap_head", if_pc, 32'hFFFF_FFFC);
    run(2, 1'b1);

    // Random mix of stalls, back-pressure and occasional redirects.
    for (int i = 0; i < 300; i++) begin
      logic st, br, fl, rdy;
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 15) == 0);
      fl  = ($urandom_range(0, 23) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      cycle(st, br, $urandom() & 32'hFFFF_FFFC, fl, $urandom() & 32'hFFFF_FFFC, rdy);
    end

    reset_pulse();
    run(4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
